// File: rtl/mcu_bus_pkg.sv
// Shared types and helpers for the MCU bus controller: FSM state encoding,
// wait-counter width and slave-index extraction from a byte address.
package mcu_bus_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    WAIT   = 2'd2,
    DONE   = 2'd3
  } bus_state_t;

  localparam int WAIT_W = 4;

  // Top idx_w bits of an addr_w-bit address, zero-extended to 32 bits.
  function automatic logic [31:0] slv_idx(input logic [63:0] addr, input int addr_w, input int idx_w);
    logic [63:0] mask;
    mask = (64'd1 << idx_w) - 64'd1;
    return 32'((addr >> (addr_w - idx_w)) & mask);
  endfunction

endpackage

// File: rtl/mcu_bus_addr_dec.sv
// Combinational address decoder: slave index, one-hot select, read-only hit
// and misaligned full-word detection for the incoming CPU request.
module mcu_bus_addr_dec
  import mcu_bus_pkg::*;
#(
  parameter int                 ADDR_WIDTH = 32,
  parameter int                 DATA_WIDTH = 32,
  parameter int                 NUM_SLV    = 4,
  parameter logic [NUM_SLV-1:0] SLV_RO     = 4'b0001,
  localparam int                IW         = $clog2(NUM_SLV)
) (
  input  logic [ADDR_WIDTH-1:0]   addr,
  input  logic [DATA_WIDTH/8-1:0] be,
  output logic [IW-1:0]           idx,
  output logic [NUM_SLV-1:0]      sel,
  output logic                    ro_hit,
  output logic                    misalign
);

  assign idx      = IW'(slv_idx(64'(addr), ADDR_WIDTH, IW));
  assign sel      = {{(NUM_SLV-1){1'b0}}, 1'b1} << idx;
  assign ro_hit   = SLV_RO[idx];
  // A full-width access must be word aligned; partial strobes may target any lane.
  assign misalign = (&be) && (addr[1:0] != 2'b00);

endmodule

// File: rtl/mcu_bus_ctrl.sv
// Bus controller between the multicycle CPU and NUM_SLV memory-mapped slaves.
// Optional access checking (read-only slaves, misaligned words) via MCU_BUS_ERR_EN.
module mcu_bus_ctrl
  import mcu_bus_pkg::*;
#(
  parameter int                   ADDR_WIDTH = 32,
  parameter int                   DATA_WIDTH = 32,
  parameter int                   NUM_SLV    = 4,
  parameter logic [4*NUM_SLV-1:0] SLV_WAIT   = 16'h0_1_0_2,
  parameter logic [NUM_SLV-1:0]   SLV_RO     = 4'b0001,
  localparam int                  IW         = $clog2(NUM_SLV)
) (
  input  logic                          sys_clk,
  input  logic                          sys_rst_n,
  input  logic                          cpu_req,
  input  logic                          cpu_we,
  input  logic [ADDR_WIDTH-1:0]         cpu_addr,
  input  logic [DATA_WIDTH-1:0]         cpu_wdata,
  input  logic [DATA_WIDTH/8-1:0]       cpu_be,
  output logic [DATA_WIDTH-1:0]         cpu_rdata,
  output logic                          cpu_ready,
`ifdef MCU_BUS_ERR_EN
  output logic                          cpu_err,
`endif
  output logic [NUM_SLV-1:0]            slv_sel,
  output logic                          slv_we,
  output logic [ADDR_WIDTH-1:0]         slv_addr,
  output logic [DATA_WIDTH-1:0]         slv_wdata,
  output logic [DATA_WIDTH/8-1:0]       slv_be,
  input  logic [NUM_SLV*DATA_WIDTH-1:0] slv_rdata
);

  bus_state_t             state_r, state_nx;
  logic [WAIT_W-1:0]      cnt_r, cnt_nx, wait_s;
  logic [IW-1:0]          idx_s, idx_r;
  logic [NUM_SLV-1:0]     dec_sel_s, sel_r, sel_nx;
  logic                   we_r, slv_we_r, slv_we_nx;
  logic                   ready_r, ready_nx, err_r, err_nx;
  logic                   accept_s, err_hit_s, ro_hit_s, misalign_s;
  logic [DATA_WIDTH-1:0]  rdata_s;

  mcu_bus_addr_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_SLV    (NUM_SLV),
    .SLV_RO     (SLV_RO)
  ) u_dec (
    .addr     (cpu_addr),
    .be       (cpu_be),
    .idx      (idx_s),
    .sel      (dec_sel_s),
    .ro_hit   (ro_hit_s),
    .misalign (misalign_s)
  );

`ifdef MCU_BUS_ERR_EN
  assign err_hit_s = (cpu_we && ro_hit_s) || misalign_s;
  assign cpu_err   = err_r;
`else
  logic unused_err_s;
  assign unused_err_s = ro_hit_s | misalign_s;
  assign err_hit_s    = 1'b0;
`endif

  assign wait_s  = SLV_WAIT[32'(idx_r) * WAIT_W +: WAIT_W];
  assign rdata_s = slv_rdata[32'(idx_r) * DATA_WIDTH +: DATA_WIDTH];

  // Next-state, wait counter and next values of the registered strobes.
  always_comb begin
    state_nx = state_r;
    cnt_nx   = cnt_r;
    accept_s = 1'b0;
    err_nx   = 1'b0;
    case (state_r)
      IDLE: begin
        if (cpu_req) begin
          accept_s = 1'b1;
          if (err_hit_s) begin
            err_nx   = 1'b1;
            state_nx = DONE;
          end else begin
            state_nx = ACCESS;
          end
        end else begin
          state_nx = IDLE;
        end
      end
      ACCESS: begin
        if (wait_s == 4'd0) begin
          state_nx = DONE;
        end else begin
          cnt_nx   = wait_s;
          state_nx = WAIT;
        end
      end
      WAIT: begin
        cnt_nx = cnt_r - 4'd1;
        if (cnt_r == 4'd1) begin
          state_nx = DONE;
        end else begin
          state_nx = WAIT;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    // ACCESS is only entered from an accept, so the live decode is the right select.
    sel_nx    = (state_nx == ACCESS) ? dec_sel_s : {NUM_SLV{1'b0}};
    slv_we_nx = (state_nx == ACCESS) && cpu_we;
    ready_nx  = (state_nx == DONE);
  end

  // FSM state, wait counter and registered handshake/select strobes.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_r  <= IDLE;
      cnt_r    <= 4'd0;
      sel_r    <= {NUM_SLV{1'b0}};
      slv_we_r <= 1'b0;
      ready_r  <= 1'b0;
      err_r    <= 1'b0;
    end else begin
      state_r  <= state_nx;
      cnt_r    <= cnt_nx;
      sel_r    <= sel_nx;
      slv_we_r <= slv_we_nx;
      ready_r  <= ready_nx;
      err_r    <= err_nx;
    end
  end

  // Request capture at accept; held until the next accept.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      idx_r     <= {IW{1'b0}};
      we_r      <= 1'b0;
      slv_addr  <= {ADDR_WIDTH{1'b0}};
      slv_wdata <= {DATA_WIDTH{1'b0}};
      slv_be    <= {(DATA_WIDTH/8){1'b0}};
    end else if (accept_s) begin
      idx_r     <= idx_s;
      we_r      <= cpu_we;
      slv_addr  <= cpu_addr;
      slv_wdata <= cpu_wdata;
      slv_be    <= cpu_be;
    end
  end

  assign slv_sel   = sel_r;
  assign slv_we    = slv_we_r;
  assign cpu_ready = ready_r;
  // Slaves read synchronously, so their data is only valid in the cycle after select;
  // it is gated rather than re-registered to keep DONE at cycle 2+W.
  assign cpu_rdata = (ready_r && !we_r && !err_r) ? rdata_s : {DATA_WIDTH{1'b0}};

endmodule
